id_stage_hz: RTL and testbench

Parametrised decode stage with an integrated ID/EX pipeline register, load-use hazard detection, bubble insertion, flush and a stall performance counter. Sits between the IF/ID register and the execute stage. Contains one `regfile`, one `immd_gen` and one `i_decoder`. All outputs to execute are registered, so the ID/EX register is no longer a separate block.

---
 rtl/id_stage_hz.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_id_stage_hz.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hz.sv
// rtl/id_stage_hz.sv - decode stage with integrated ID/EX register, load-use hazard detection and stall counter
//
// Modules in this file:
//   i_decoder  : RV32I-style control decode from the instruction word
//   immd_gen   : sign-extended immediate for I/S/B/U/J formats (0 for R-type)
//   regfile    : NUM_REGS x WORD_SIZE, sync reset clear, x0 hardwired to 0
//   id_stage_hz: top; decode + regfile read captured into the ID/EX register
//
// id_stage_hz ports:
//   clk, rst                 : clock, synchronous active-high reset
//   if_valid, pc, instr      : instruction presented by IF/ID
//   ex_stall, flush          : execute back-pressure, redirect kill
//   reg_write, rd_select, rd_data : write-back port into the regfile
//   id_stall                 : combinational hold request to IF and IF/ID
//   ex_valid .. jump         : registered ID/EX contents
//   stall_cnt                : saturating count of inserted load-use bubbles
//
// Build option: define ID_WB_BYPASS_EN to forward the write-back value into
// the operands captured in the same cycle.

module i_decoder #(
    parameter int WORD_SIZE = 32,
    parameter int REG_SEL   = 5
) (
    input  logic [WORD_SIZE-1:0] instr,
    output logic [REG_SEL-1:0]   rs1,
    output logic [REG_SEL-1:0]   rs2,
    output logic [REG_SEL-1:0]   rd,
    output logic [3:0]           alu_op,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src,
    output logic                 branch,
    output logic                 jump
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign unused_bits = ^{instr[31], instr[29:25]};

    // rs2 is always taken from its field, even for formats without rs2;
    // hazard detection on it is deliberately conservative.
    assign rs1 = REG_SEL'(instr[19:15]);
    assign rs2 = REG_SEL'(instr[24:20]);
    assign rd  = REG_SEL'(instr[11:7]);

    always_comb begin
        alu_op     = 4'b0000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        case (opcode)
            7'b0110011: begin                       // OP
                alu_op    = {instr[30], funct3};
                reg_write = 1'b1;
            end
            7'b0010011: begin                       // OP-IMM; bit30 only meaningful for SRAI
                alu_op    = {(funct3 == 3'b101) & instr[30], funct3};
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            7'b0000011: begin                       // LOAD
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                alu_src    = 1'b1;
            end
            7'b0100011: begin                       // STORE
                mem_write = 1'b1;
                alu_src   = 1'b1;
            end
            7'b1100011: begin                       // BRANCH compares via subtract
                alu_op = 4'b1000;
                branch = 1'b1;
            end
            7'b1101111: begin                       // JAL
                jump      = 1'b1;
                reg_write = 1'b1;
            end
            7'b1100111: begin                       // JALR
                jump      = 1'b1;
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            7'b0110111: begin                       // LUI: ALU passes the immediate through
                alu_op    = 4'b1111;
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            7'b0010111: begin                       // AUIPC: execute adds pc + immediate
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

module immd_gen #(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] immd
);
    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            7'b0100011:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            7'b1100011:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {instr[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign immd = WORD_SIZE'(imm32);
endmodule

module regfile #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_SEL-1:0]   wsel,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [REG_SEL-1:0]   rsel1,
    input  logic [REG_SEL-1:0]   rsel2,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic [WORD_SIZE-1:0] rdata2
);
    logic [WORD_SIZE-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && (wsel != '0)) begin
            regs[wsel] <= wdata;
        end
    end

    assign rdata1 = (rsel1 == '0) ? '0 : regs[rsel1];
    assign rdata2 = (rsel2 == '0) ? '0 : regs[rsel2];
endmodule

module id_stage_hz #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int ADDR_SIZE = 10,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [ADDR_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 ex_stall,
    input  logic                 flush,
    input  logic                 reg_write,
    input  logic [REG_SEL-1:0]   rd_select,
    input  logic [WORD_SIZE-1:0] rd_data,
    output logic                 id_stall,
    output logic                 ex_valid,
    output logic [ADDR_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] immd,
    output logic [WORD_SIZE-1:0] data1,
    output logic [WORD_SIZE-1:0] data2,
    output logic [3:0]           alu_op,
    output logic [REG_SEL-1:0]   rd,
    output logic [REG_SEL-1:0]   rs1,
    output logic [REG_SEL-1:0]   rs2,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write_out,
    output logic                 alu_src,
    output logic                 branch,
    output logic                 jump,
    output logic [CNT_W-1:0]     stall_cnt
);
    logic [REG_SEL-1:0]   d_rs1, d_rs2, d_rd;
    logic [3:0]           d_alu_op;
    logic                 d_mem_read, d_mem_write, d_mem_to_reg, d_reg_write;
    logic                 d_alu_src, d_branch, d_jump;
    logic [WORD_SIZE-1:0] d_immd, rf_data1, rf_data2, op1, op2;
    logic                 lu, ex_clr;

    i_decoder #(.WORD_SIZE(WORD_SIZE), .REG_SEL(REG_SEL)) u_dec (
        .instr(instr), .rs1(d_rs1), .rs2(d_rs2), .rd(d_rd), .alu_op(d_alu_op),
        .mem_read(d_mem_read), .mem_write(d_mem_write), .mem_to_reg(d_mem_to_reg),
        .reg_write(d_reg_write), .alu_src(d_alu_src), .branch(d_branch), .jump(d_jump)
    );

    immd_gen #(.WORD_SIZE(WORD_SIZE)) u_imm (.instr(instr), .immd(d_immd));

    regfile #(.WORD_SIZE(WORD_SIZE), .NUM_REGS(NUM_REGS), .REG_SEL(REG_SEL)) u_rf (
        .clk(clk), .rst(rst), .we(reg_write), .wsel(rd_select), .wdata(rd_data),
        .rsel1(d_rs1), .rsel2(d_rs2), .rdata1(rf_data1), .rdata2(rf_data2)
    );

`ifdef ID_WB_BYPASS_EN
    assign op1 = (reg_write && (rd_select != '0) && (rd_select == d_rs1)) ? rd_data : rf_data1;
    assign op2 = (reg_write && (rd_select != '0) && (rd_select == d_rs2)) ? rd_data : rf_data2;
`else
    assign op1 = rf_data1;
    assign op2 = rf_data2;
`endif

    assign lu = ex_valid && mem_read && (rd != '0) && if_valid &&
                ((rd == d_rs1) || (rd == d_rs2));

    assign id_stall = (lu | ex_stall) & ~flush;

    // ex_stall outranks lu: the bubble only goes in when execute can accept.
    assign ex_clr = rst | flush | (~ex_stall & lu);

    always_ff @(posedge clk) begin
        if (ex_clr) begin
            ex_valid      <= 1'b0;
            pc_out        <= '0;
            immd          <= '0;
            data1         <= '0;
            data2         <= '0;
            alu_op        <= '0;
            rd            <= '0;
            rs1           <= '0;
            rs2           <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            reg_write_out <= 1'b0;
            alu_src       <= 1'b0;
            branch        <= 1'b0;
            jump          <= 1'b0;
        end else if (!ex_stall) begin
            ex_valid      <= if_valid;
            pc_out        <= if_valid ? pc       : '0;
            immd          <= if_valid ? d_immd   : '0;
            data1         <= if_valid ? op1      : '0;
            data2         <= if_valid ? op2      : '0;
            alu_op        <= if_valid ? d_alu_op : '0;
            rd            <= if_valid ? d_rd     : '0;
            rs1           <= if_valid ? d_rs1    : '0;
            rs2           <= if_valid ? d_rs2    : '0;
            mem_read      <= if_valid & d_mem_read;
            mem_write     <= if_valid & d_mem_write;
            mem_to_reg    <= if_valid & d_mem_to_reg;
            reg_write_out <= if_valid & d_reg_write;
            alu_src       <= if_valid & d_alu_src;
            branch        <= if_valid & d_branch;
            jump          <= if_valid & d_jump;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!flush && !ex_stall && lu && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_stage_hz.sv
// tb/tb_id_stage_hz.sv - scoreboard bench for id_stage_hz with directed instruction vectors
module tb_id_stage_hz;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [9:0]  pc = '0;
    logic [31:0] instr = '0;
    logic        ex_stall = 1'b0;
    logic        flush = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  rd_select = '0;
    logic [31:0] rd_data = '0;
    logic        id_stall, ex_valid;
    logic [9:0]  pc_out;
    logic [31:0] immd, data1, data2;
    logic [3:0]  alu_op;
    logic [4:0]  rd, rs1, rs2;
    logic        mem_read, mem_write, mem_to_reg, reg_write_out, alu_src, branch, jump;
    logic [15:0] stall_cnt;

    id_stage_hz dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .pc(pc), .instr(instr),
        .ex_stall(ex_stall), .flush(flush), .reg_write(reg_write),
        .rd_select(rd_select), .rd_data(rd_data), .id_stall(id_stall),
        .ex_valid(ex_valid), .pc_out(pc_out), .immd(immd), .data1(data1),
        .data2(data2), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write_out(reg_write_out), .alu_src(alu_src), .branch(branch),
        .jump(jump), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          cs;
        logic        st;
        logic        v;
        logic [9:0]  p;
        logic [31:0] im, d1, d2;
        logic [3:0]  ao;
        logic [4:0]  rdv, r1, r2;
        logic [6:0]  c;
        logic [15:0] cn;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] ADDI5  = 32'h0070_0293;   // addi x5,x0,7
    localparam logic [31:0] ADD655 = 32'h0052_8333;   // add  x6,x5,x5
    localparam logic [31:0] LW31   = 32'h0000_A183;   // lw   x3,0(x1)
    localparam logic [31:0] ADD432 = 32'h0021_8233;   // add  x4,x3,x2
    localparam logic [31:0] LW01   = 32'h0000_A003;   // lw   x0,0(x1)
    localparam logic [31:0] ADD400 = 32'h0000_0233;   // add  x4,x0,x0
    localparam logic [31:0] ADD870 = 32'h0003_8433;   // add  x8,x7,x0
    localparam logic [31:0] ADD800 = 32'h0000_0433;   // add  x8,x0,x0
    // {mem_read,mem_write,mem_to_reg,reg_write_out,alu_src,branch,jump}
    localparam logic [6:0]  C_ALUI = 7'b0001100;
    localparam logic [6:0]  C_R    = 7'b0001000;
    localparam logic [6:0]  C_LD   = 7'b1011100;
`ifdef ID_WB_BYPASS_EN
    localparam logic [31:0] BYP_D1 = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] BYP_D1 = 32'h1111_1111;
`endif

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic drive(input logic r, input logic iv, input logic es, input logic fl,
                         input logic [9:0] p, input logic [31:0] ins,
                         input logic we, input logic [4:0] ws, input logic [31:0] wd);
        rst = r; if_valid = iv; ex_stall = es; flush = fl;
        pc = p; instr = ins; reg_write = we; rd_select = ws; rd_data = wd;
    endtask

    task automatic expect_out(input bit cs, input logic st, input logic v, input logic [9:0] p,
                              input logic [31:0] im, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [3:0] ao, input logic [4:0] rdv, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [6:0] c, input logic [15:0] cn);
        exp_t e;
        e.cs = cs; e.st = st; e.v = v; e.p = p; e.im = im; e.d1 = d1; e.d2 = d2;
        e.ao = ao; e.rdv = rdv; e.r1 = r1; e.r2 = r2; e.c = c; e.cn = cn;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic expect_zero(input bit cs, input logic st, input logic [15:0] cn);
        expect_out(cs, st, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, cn);
    endtask

    // Monitor: id_stall is checked before the edge, registered outputs after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.cs) chk("id_stall", {31'b0, id_stall}, {31'b0, e.st});
                @(posedge clk);
                #1;
                chk("ex_valid",  {31'b0, ex_valid}, {31'b0, e.v});
                chk("pc_out",    {22'b0, pc_out},   {22'b0, e.p});
                chk("immd",      immd,  e.im);
                chk("data1",     data1, e.d1);
                chk("data2",     data2, e.d2);
                chk("alu_op",    {28'b0, alu_op}, {28'b0, e.ao});
                chk("rd",        {27'b0, rd},  {27'b0, e.rdv});
                chk("rs1",       {27'b0, rs1}, {27'b0, e.r1});
                chk("rs2",       {27'b0, rs2}, {27'b0, e.r2});
                chk("ctrl",      {25'b0, mem_read, mem_write, mem_to_reg, reg_write_out,
                                  alu_src, branch, jump}, {25'b0, e.c});
                chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, e.cn});
            end
        end
    end

    initial begin
        @(negedge clk);
        // reset held two cycles with a valid instruction presented
        drive(1, 1, 0, 0, 10'h010, ADDI5, 0, 0, 0);          expect_zero(0, 0, 0);
        drive(1, 1, 0, 0, 10'h010, ADDI5, 0, 0, 0);          expect_zero(1, 0, 0);
        // preload x1, x2, x7 through write-back with no instruction valid
        drive(0, 0, 0, 0, 10'h000, 32'h0, 1, 5'd1, 32'h0000_0100); expect_zero(1, 0, 0);
        drive(0, 0, 0, 0, 10'h000, 32'h0, 1, 5'd2, 32'h0000_0022); expect_zero(1, 0, 0);
        drive(0, 0, 0, 0, 10'h000, 32'h0, 1, 5'd7, 32'h1111_1111); expect_zero(1, 0, 0);
        // plain flow
        drive(0, 1, 0, 0, 10'h010, ADDI5, 0, 0, 0);
        expect_out(1, 0, 1, 10'h010, 32'd7, 32'h0, 32'h1111_1111, 4'h0, 5'd5, 5'd0, 5'd7, C_ALUI, 0);
        drive(0, 1, 0, 0, 10'h014, ADD655, 0, 0, 0);
        expect_out(1, 0, 1, 10'h014, 32'd0, 32'h0, 32'h0, 4'h0, 5'd6, 5'd5, 5'd5, C_R, 0);
        // load-use: one bubble, then the dependent add
        drive(0, 1, 0, 0, 10'h018, LW31, 0, 0, 0);
        expect_out(1, 0, 1, 10'h018, 32'd0, 32'h100, 32'h0, 4'h0, 5'd3, 5'd1, 5'd0, C_LD, 0);
        drive(0, 1, 0, 0, 10'h01C, ADD432, 0, 0, 0);         expect_zero(1, 1, 1);
        drive(0, 1, 0, 0, 10'h01C, ADD432, 0, 0, 0);
        expect_out(1, 0, 1, 10'h01C, 32'd0, 32'h0, 32'h22, 4'h0, 5'd4, 5'd3, 5'd2, C_R, 1);
        // load into x0 never stalls
        drive(0, 1, 0, 0, 10'h020, LW01, 0, 0, 0);
        expect_out(1, 0, 1, 10'h020, 32'd0, 32'h100, 32'h0, 4'h0, 5'd0, 5'd1, 5'd0, C_LD, 1);
        drive(0, 1, 0, 0, 10'h024, ADD400, 0, 0, 0);
        expect_out(1, 0, 1, 10'h024, 32'd0, 32'h0, 32'h0, 4'h0, 5'd4, 5'd0, 5'd0, C_R, 1);
        // flush in the hazard cycle
        drive(0, 1, 0, 0, 10'h028, LW31, 0, 0, 0);
        expect_out(1, 0, 1, 10'h028, 32'd0, 32'h100, 32'h0, 4'h0, 5'd3, 5'd1, 5'd0, C_LD, 1);
        drive(0, 1, 0, 1, 10'h02C, ADD432, 0, 0, 0);         expect_zero(1, 0, 1);
        // ex_stall holds for three cycles
        drive(0, 1, 0, 0, 10'h030, ADDI5, 0, 0, 0);
        expect_out(1, 0, 1, 10'h030, 32'd7, 32'h0, 32'h1111_1111, 4'h0, 5'd5, 5'd0, 5'd7, C_ALUI, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 10'h034, ADD432, 0, 0, 0);
            expect_out(1, 1, 1, 10'h030, 32'd7, 32'h0, 32'h1111_1111, 4'h0, 5'd5, 5'd0, 5'd7, C_ALUI, 1);
        end
        // ex_stall together with lu: hold, no count, then bubble
        drive(0, 1, 0, 0, 10'h038, LW31, 0, 0, 0);
        expect_out(1, 0, 1, 10'h038, 32'd0, 32'h100, 32'h0, 4'h0, 5'd3, 5'd1, 5'd0, C_LD, 1);
        drive(0, 1, 1, 0, 10'h03C, ADD432, 0, 0, 0);
        expect_out(1, 1, 1, 10'h038, 32'd0, 32'h100, 32'h0, 4'h0, 5'd3, 5'd1, 5'd0, C_LD, 1);
        drive(0, 1, 0, 0, 10'h03C, ADD432, 0, 0, 0);         expect_zero(1, 1, 2);
        drive(0, 1, 0, 0, 10'h03C, ADD432, 0, 0, 0);
        expect_out(1, 0, 1, 10'h03C, 32'd0, 32'h0, 32'h22, 4'h0, 5'd4, 5'd3, 5'd2, C_R, 2);
        // reset during a load-use stall clears everything, including the counter
        drive(0, 1, 0, 0, 10'h040, LW31, 0, 0, 0);
        expect_out(1, 0, 1, 10'h040, 32'd0, 32'h100, 32'h0, 4'h0, 5'd3, 5'd1, 5'd0, C_LD, 2);
        drive(1, 1, 0, 0, 10'h044, ADD432, 0, 0, 0);         expect_zero(1, 1, 0);
        drive(0, 0, 0, 0, 10'h000, 32'h0, 0, 0, 0);          expect_zero(1, 0, 0);
        // same-cycle write-back of the source register
        drive(0, 0, 0, 0, 10'h000, 32'h0, 1, 5'd7, 32'h1111_1111); expect_zero(1, 0, 0);
        drive(0, 1, 0, 0, 10'h044, ADD870, 1, 5'd7, 32'hDEAD_BEEF);
        expect_out(1, 0, 1, 10'h044, 32'd0, BYP_D1, 32'h0, 4'h0, 5'd8, 5'd7, 5'd0, C_R, 0);
        // writes to x0 are dropped and never bypassed
        drive(0, 0, 0, 0, 10'h000, 32'h0, 1, 5'd0, 32'h0000_0055); expect_zero(1, 0, 0);
        drive(0, 1, 0, 0, 10'h048, ADD800, 1, 5'd0, 32'h0000_0055);
        expect_out(1, 0, 1, 10'h048, 32'd0, 32'h0, 32'h0, 4'h0, 5'd8, 5'd0, 5'd0, C_R, 0);
        drive(0, 0, 0, 0, 10'h000, 32'h0, 0, 0, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
